requant_pipe: RTL

Multi-lane, per-channel INT32 to INT8 requantizer with a valid/ready handshake. It is the next generation of the single-value requantize primitive. It adds:
- per-channel scale, shift and zero point, held in an internal table;
- round-half-up arithmetic shift;
- optional ReLU;
- a 3-stage pipeline with backpressure;
- a saturation counter.

It sits between the MAC array accumulator drain and the INT8 output buffer.

---
 rtl/requant_pkg.sv | 40 ++++
 rtl/requant_lane.sv | 89 ++++++++
 rtl/requant_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/requant_pkg.sv
// Shared types, widths and the INT8 saturation helper for the requantizer.
package requant_pkg;

  localparam int unsigned ACC_W       = 32;
  localparam int unsigned OUT_W       = 8;
  localparam int unsigned CFG_SCALE_W = 16;
  localparam int unsigned CFG_SHIFT_W = 5;
  // Width of r + zp ahead of clamping; r needs ACC_W+1 bits after the shift.
  localparam int unsigned SUM_W       = 36;

  typedef struct packed {
    logic [CFG_SCALE_W-1:0]  scale;
    logic [CFG_SHIFT_W-1:0]  shift;
    logic signed [OUT_W-1:0] zp;
  } requant_cfg_t;

  typedef struct packed {
    logic                    clamped;
    logic signed [OUT_W-1:0] val;
  } sat8_t;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 127;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -128;

  function automatic sat8_t sat_clamp8(input logic signed [SUM_W-1:0] v);
    sat8_t res;
    if (v > SAT_MAX) begin
      res.clamped = 1'b1;
      res.val     = 8'sh7F;
    end else if (v < SAT_MIN) begin
      res.clamped = 1'b1;
      res.val     = 8'sh80;
    end else begin
      res.clamped = 1'b0;
      res.val     = v[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantizer: S1 multiply, S2 round-half-up shift, S3 zp/ReLU/clamp.
module requant_lane
  import requant_pkg::*;
#(
  parameter int unsigned SCALE_W = CFG_SCALE_W,
  parameter int unsigned SHIFT_W = CFG_SHIFT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [SCALE_W-1:0]      scale_i,
  input  logic [SHIFT_W-1:0]      shift_i,
  input  logic signed [OUT_W-1:0] zp_i,
  input  logic                    relu_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    clamp_o
);

  localparam int unsigned PROD_W = ACC_W + SCALE_W;
  localparam int unsigned RND_W  = PROD_W + 1;
  localparam int unsigned R_W    = ACC_W + 1;
  localparam int unsigned N_W    = $clog2(SCALE_W + (1 << SHIFT_W));

  logic signed [PROD_W-1:0] acc_ext, scale_ext, prod_d, prod_q;
  logic [SHIFT_W-1:0]       shift1_q;
  logic signed [OUT_W-1:0]  zp1_q, zp2_q;
  logic                     relu1_q, relu2_q;

  logic [N_W-1:0]           n;
  logic signed [RND_W-1:0]  rnd, rsh;
  logic signed [R_W-1:0]    r_d, r_q;

  logic signed [SUM_W-1:0]  v, zpx;
  sat8_t                    sat;
  logic signed [OUT_W-1:0]  data_q;
  logic                     clamp_q;

  always_comb begin
    acc_ext   = {{SCALE_W{acc_i[ACC_W-1]}}, acc_i};
    scale_ext = {{ACC_W{1'b0}}, scale_i};
    prod_d    = acc_ext * scale_ext;
  end

  // One extra bit above the product keeps the rounding bias from overflowing.
  always_comb begin
    n   = N_W'(SCALE_W) + N_W'(shift1_q);
    rnd = RND_W'(prod_q) + (RND_W'(1) << (n - N_W'(1)));
    rsh = rnd >>> n;
    r_d = R_W'(rsh);
  end

  always_comb begin
    zpx = SUM_W'(zp2_q);
    v   = SUM_W'(r_q) + zpx;
    if (relu2_q && (v < zpx)) begin
      v = zpx;
    end
    sat = sat_clamp8(v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      shift1_q <= '0;
      zp1_q    <= '0;
      relu1_q  <= 1'b0;
      r_q      <= '0;
      zp2_q    <= '0;
      relu2_q  <= 1'b0;
      data_q   <= '0;
      clamp_q  <= 1'b0;
    end else if (en_i) begin
      prod_q   <= prod_d;
      shift1_q <= shift_i;
      zp1_q    <= zp_i;
      relu1_q  <= relu_i;
      r_q      <= r_d;
      zp2_q    <= zp1_q;
      relu2_q  <= relu1_q;
      data_q   <= sat.val;
      clamp_q  <= sat.clamped;
    end
  end

  assign data_o  = data_q;
  assign clamp_o = clamp_q;

endmodule

// File: rtl/requant_pipe.sv
// Multi-lane per-channel INT32->INT8 requantizer with valid/ready handshake,
// channel table, lockstep 3-stage pipeline and saturation counter.
module requant_pipe
  import requant_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned NUM_CH  = 64,
  parameter int unsigned SCALE_W = CFG_SCALE_W,
  parameter int unsigned SHIFT_W = CFG_SHIFT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ACC_W-1:0]    in_acc,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_data,
  output logic                      out_last,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
  input  logic [SCALE_W-1:0]        cfg_scale,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic [OUT_W-1:0]          cfg_zp,
  input  logic [$clog2(NUM_CH):0]   cfg_num_ch,
  input  logic                      cfg_relu,
  input  logic                      sat_clr,
  output logic [15:0]               sat_cnt
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam logic [CH_W:0] STEP = (CH_W + 1)'(LANES);

  logic adv, acc_fire, hand;

  logic [CH_W-1:0] ch_ptr_q, ch_ptr_d;
  logic [CH_W:0]   ch_nxt;

  requant_cfg_t tab_q [NUM_CH];

  logic v1_q, v2_q, out_valid_q;
  logic last1_q, last2_q, out_last_q;

  logic [LANES-1:0] clamp;
  logic [CNT_W-1:0] n_clamp;
  logic [16:0]      sat_sum;
  logic [15:0]      sat_cnt_q, sat_cnt_d;

  assign in_ready  = !out_valid_q || out_ready;
  assign adv       = in_ready;
  assign acc_fire  = in_valid && in_ready;
  assign hand      = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sat_cnt   = sat_cnt_q;

  // in_last and the num_ch boundary both force zero, so coinciding wraps once.
  always_comb begin
    ch_nxt   = {1'b0, ch_ptr_q} + STEP;
    ch_ptr_d = ch_ptr_q;
    if (acc_fire) begin
      if (in_last || (ch_nxt == cfg_num_ch)) begin
        ch_ptr_d = '0;
      end else begin
        ch_ptr_d = ch_nxt[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tab_q[cfg_addr] <= {cfg_scale, cfg_shift, cfg_zp};
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    requant_cfg_t ent;
    assign ent = tab_q[ch_ptr_q + CH_W'(gi)];

    requant_lane #(
      .SCALE_W(SCALE_W),
      .SHIFT_W(SHIFT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .acc_i  (in_acc[gi*ACC_W +: ACC_W]),
      .scale_i(ent.scale),
      .shift_i(ent.shift),
      .zp_i   (ent.zp),
      .relu_i (cfg_relu),
      .data_o (out_data[gi*OUT_W +: OUT_W]),
      .clamp_o(clamp[gi])
    );
  end

  always_comb begin
    n_clamp = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      n_clamp = n_clamp + CNT_W'(clamp[i]);
    end
    sat_sum   = {1'b0, sat_cnt_q} + 17'(n_clamp);
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (hand) begin
      sat_cnt_d = sat_sum[16] ? '1 : sat_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_ptr_q    <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      last1_q     <= 1'b0;
      last2_q     <= 1'b0;
      out_last_q  <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      ch_ptr_q  <= ch_ptr_d;
      sat_cnt_q <= sat_cnt_d;
      if (adv) begin
        v1_q        <= in_valid;
        last1_q     <= in_last;
        v2_q        <= v1_q;
        last2_q     <= last1_q;
        out_valid_q <= v2_q;
        out_last_q  <= last2_q;
      end
    end
  end

endmodule
